// File: rtl/iq_window_feature_engine.sv
// iq_window_feature_engine
//
// Streaming I/Q window integrator. After a trigger it accepts WINDOW_SIZE valid
// samples, integrates the pre-shifted I and Q operands into NUM_WINDOWS equal
// segments, presents the post-shifted features to the classifier, samples the
// classifier result CLS_LATENCY cycles later and writes it to BRAM.
//
// State table
//   state   | meaning
//   IDLE    | waiting for trigger
//   LOAD    | accumulating samples (in_TVALID=0 cycles are stalls)
//   WAIT    | classifier latency countdown, pred_in sampled at terminal count
//   STORE   | one-cycle BRAM write, address advances afterwards
//
// Ports
//   ap_clk, ap_rst_n    clock, async active-low reset
//   clear               synchronous soft clear (back to IDLE, zero addr/drops)
//   trigger             start request, counted as dropped when not IDLE
//   in_TDATA/in_TVALID  I=[31:18], Q=[17:4]; no backpressure
//   feat_data/valid     packed features and their one-cycle strobe
//   pred_in             classifier output
//   out_ADDR/DATA/WE    BRAM write port, address wraps
//   busy                state != IDLE
//   drop_count          saturating count of rejected triggers
module iq_window_feature_engine #(
    parameter int WINDOW_SIZE    = 400,
    parameter int NUM_WINDOWS    = 2,
    parameter int IQ_WIDTH_IN    = 14,
    parameter int SHIFT_M        = 9,
    parameter int SHIFT_N        = 1,
    parameter int PRED_BITS      = 2,
    parameter int BRAM_ADDR_BITS = 14,
    parameter int CLS_LATENCY    = 4,
    localparam int SEG       = WINDOW_SIZE / NUM_WINDOWS,
    localparam int W         = IQ_WIDTH_IN - SHIFT_M,
    localparam int ACC_W     = W + $clog2(SEG),
    localparam int FEAT_W    = ACC_W - SHIFT_N,
    localparam int FEAT_BITS = 2 * NUM_WINDOWS * FEAT_W
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      clear,
    input  logic                      trigger,
    input  logic [31:0]               in_TDATA,
    input  logic                      in_TVALID,
    output logic [FEAT_BITS-1:0]      feat_data,
    output logic                      feat_valid,
    input  logic [PRED_BITS-1:0]      pred_in,
    output logic [BRAM_ADDR_BITS-1:0] out_ADDR,
    output logic [PRED_BITS-1:0]      out_DATA,
    output logic                      out_WE,
    output logic                      busy,
    output logic [15:0]               drop_count
);

    localparam int SEG_CW = (SEG > 1) ? $clog2(SEG) : 1;
    localparam int WIN_W  = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1;
    localparam int LAT_W  = $clog2(CLS_LATENCY + 1);
    localparam logic [SEG_CW-1:0] SEG_LAST = SEG_CW'(SEG - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(NUM_WINDOWS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_STORE} state_t;

    state_t                   state;
    logic [SEG_CW-1:0]        seg_cnt;
    logic [WIN_W-1:0]         win_idx;
    logic [LAT_W-1:0]         wait_cnt;
    logic signed [ACC_W-1:0]  acc_i    [NUM_WINDOWS];
    logic signed [ACC_W-1:0]  acc_q    [NUM_WINDOWS];
    logic signed [ACC_W-1:0]  acc_i_nx [NUM_WINDOWS];
    logic signed [ACC_W-1:0]  acc_q_nx [NUM_WINDOWS];
    logic [FEAT_BITS-1:0]     feat_next;

    // The top W bits of each field are the floor-shifted operand; the size
    // cast of a signed value sign-extends it to the accumulator width.
    logic signed [W-1:0]      op_i, op_q;
    logic signed [ACC_W-1:0]  ext_i, ext_q;
    logic                     unused_tdata;

    assign op_i  = in_TDATA[31 -: W];
    assign op_q  = in_TDATA[17 -: W];
    assign ext_i = ACC_W'(op_i);
    assign ext_q = ACC_W'(op_q);
    assign unused_tdata = ^in_TDATA;

    // Accumulator values including the current sample, so the features
    // registered on the last sample already contain it.
    always_comb begin
        feat_next = '0;
        for (int k = 0; k < NUM_WINDOWS; k++) begin
            acc_i_nx[k] = acc_i[k];
            acc_q_nx[k] = acc_q[k];
            if (WIN_W'(k) == win_idx) begin
                acc_i_nx[k] = acc_i[k] + ext_i;
                acc_q_nx[k] = acc_q[k] + ext_q;
            end
            feat_next[2*k*FEAT_W +: FEAT_W]     = acc_i_nx[k][ACC_W-1:SHIFT_N];
            feat_next[(2*k+1)*FEAT_W +: FEAT_W] = acc_q_nx[k][ACC_W-1:SHIFT_N];
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state      <= S_IDLE;
            seg_cnt    <= '0;
            win_idx    <= '0;
            wait_cnt   <= '0;
            for (int k = 0; k < NUM_WINDOWS; k++) begin
                acc_i[k] <= '0;
                acc_q[k] <= '0;
            end
            feat_data  <= '0;
            feat_valid <= 1'b0;
            out_ADDR   <= '0;
            out_DATA   <= '0;
            out_WE     <= 1'b0;
            busy       <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            state      <= S_IDLE;
            feat_valid <= 1'b0;
            out_WE     <= 1'b0;
            busy       <= 1'b0;
            out_ADDR   <= '0;
            drop_count <= '0;
        end else begin
            feat_valid <= 1'b0;
            out_WE     <= 1'b0;
            if (trigger && state != S_IDLE && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        state   <= S_LOAD;
                        busy    <= 1'b1;
                        seg_cnt <= '0;
                        win_idx <= '0;
                        for (int k = 0; k < NUM_WINDOWS; k++) begin
                            acc_i[k] <= '0;
                            acc_q[k] <= '0;
                        end
                    end
                end
                S_LOAD: begin
                    if (in_TVALID) begin
                        acc_i <= acc_i_nx;
                        acc_q <= acc_q_nx;
                        if (seg_cnt == SEG_LAST) begin
                            seg_cnt <= '0;
                            if (win_idx == WIN_LAST) begin
                                state      <= S_WAIT;
                                feat_data  <= feat_next;
                                feat_valid <= 1'b1;
                                wait_cnt   <= LAT_W'(CLS_LATENCY);
                            end else begin
                                win_idx <= win_idx + WIN_W'(1);
                            end
                        end else begin
                            seg_cnt <= seg_cnt + SEG_CW'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        out_DATA <= pred_in;
                        out_WE   <= 1'b1;
                        state    <= S_STORE;
                    end else begin
                        wait_cnt <= wait_cnt - LAT_W'(1);
                    end
                end
                S_STORE: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    out_ADDR <= out_ADDR + BRAM_ADDR_BITS'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/iq_window_feature_engine.md
# iq_window_feature_engine

Streaming front end that turns a triggered readout of I/Q samples into per-window integrated features for the downstream classifier netlist, and stores the returned prediction in PL BRAM. It generalises the fixed two-window, sample-buffered readout wrapper to any NUM_WINDOWS and sizes its widths from its parameters. It accumulates on the fly instead of buffering every sample, has a fixed-latency classifier handshake and wrapping result addresses, and counts triggers that arrive while it is busy.

## Interface
- WINDOW_SIZE, 400: valid samples captured per trigger.
- NUM_WINDOWS, 2: number of equal segments. Must divide WINDOW_SIZE. SEG = WINDOW_SIZE/NUM_WINDOWS.
- IQ_WIDTH_IN, 14: raw signed I/Q width.
- SHIFT_M, 9: pre-accumulation arithmetic right shift. W = IQ_WIDTH_IN-SHIFT_M.
- SHIFT_N, 1: post-accumulation arithmetic right shift.
- PRED_BITS, 2: prediction width.
- BRAM_ADDR_BITS, 14: result address width.
- CLS_LATENCY, 4: classifier latency in cycles, at least 1.
- Derived: ACC_W = W+$clog2(SEG); FEAT_W = ACC_W-SHIFT_N; FEAT_BITS = 2*NUM_WINDOWS*FEAT_W.

Ports:
- ap_clk  in  1  clock. Single clock domain.
- ap_rst_n  in  1  reset. Asynchronous assert, active-low.
- clear  in  1  synchronous soft clear.
- trigger  in  1  single-cycle start request.
- in_TDATA  in  32  I = [31:18], Q = [17:4], [3:0] ignored.
- in_TVALID  in  1  sample valid. There is no backpressure.
- feat_data  out  FEAT_BITS  packed features to the classifier.
- feat_valid  out  1  one-cycle pulse marking new feat_data.
- pred_in  in  PRED_BITS  classifier output.
- out_ADDR  out  BRAM_ADDR_BITS  BRAM write address.
- out_DATA  out  PRED_BITS  BRAM write data.
- out_WE  out  1  BRAM write enable.
- busy  out  1  high when state ≠ IDLE.
- drop_count  out  16  count of rejected triggers, saturating.

## Operation
- States: IDLE, LOAD, WAIT, STORE.
- IDLE -> LOAD when trigger=1.
  - On entry, all 2*NUM_WINDOWS accumulators, the sample counter and the window index clear to 0.
- LOAD: each cycle with in_TVALID=1 accepts one sample.
  - Operands are in_TDATA[31:18+SHIFT_M] and in_TDATA[17:4+SHIFT_M], each a W-bit signed value (floor shift).
  - Each operand is sign-extended to ACC_W and added to the I or Q accumulator of the current window.
  - The window index advances after every SEG accepted samples.
  - Cycles with in_TVALID=0 are stalls and change nothing.
  - The trigger-cycle sample is not captured.
- LOAD -> WAIT on the cycle the WINDOW_SIZE-th sample is accepted.
  - The next cycle, feat_data is registered. Window k I goes to bits [2k*FEAT_W +: FEAT_W] and window k Q to [(2k+1)*FEAT_W +: FEAT_W].
  - Each field is acc>>>SHIFT_N (arithmetic shift, LSBs dropped).
  - feat_valid=1 for exactly that one cycle.
  - feat_data holds until the next feat_valid.
- WAIT: a counter runs CLS_LATENCY cycles. pred_in is sampled CLS_LATENCY cycles after the feat_valid cycle, then the block moves to STORE.
- STORE: lasts one cycle, with out_WE=1 and out_DATA = sampled prediction. Next state is IDLE.
  - out_ADDR is the write address. It increments the following cycle and wraps from 2^BRAM_ADDR_BITS-1 to 0.
  - The first write after reset goes to address 0.
- A trigger seen in any state other than IDLE is ignored; it increments drop_count, which saturates at 0xFFFF.
  - A trigger in the STORE cycle counts as dropped.
- clear=1, whatever the state:
  - Returns the block to IDLE, aborting any run with no write.
  - Zeroes out_ADDR and drop_count and drops feat_valid/out_WE.
  - A trigger in the same cycle is ignored and not counted.
- Accumulators cannot overflow: |sum| ≤ SEG*2^(W-1) ≤ 2^(ACC_W-1).

## Timing
- Reset value of every output is 0: feat_data, feat_valid, out_ADDR, out_DATA, out_WE, busy, drop_count. The state is IDLE.
- Reset asserted mid-run aborts immediately with no write, and no output glitches high.
- Trigger at cycle 0 with continuous in_TVALID:
  - Samples are captured in cycles 1..WINDOW_SIZE.
  - feat_valid is at cycle WINDOW_SIZE+1.
  - out_WE is at cycle WINDOW_SIZE+CLS_LATENCY+2.
  - IDLE is at WINDOW_SIZE+CLS_LATENCY+3, the earliest cycle a trigger is accepted.
- Each stall cycle adds exactly one cycle.
- busy rises the cycle after the trigger and falls the cycle after STORE.

## Test plan
- I raw = +512, Q raw = -512 constant, defaults, pred_in = 2'b10 -> feat fields from LSB are 100, -100, 100, -100 (FEAT_W = 12), feat_valid at cycle 401, out_WE at cycle 406 with out_ADDR=0 and out_DATA=2'b10.
- I raw = -1, Q raw = -8192 -> per-window I = -200>>>1 = -100 and Q = -3200>>>1 = -1600, confirming floor shifts and sign extension.
- Same run with in_TVALID low every other cycle -> identical features, out_WE delayed by exactly the number of stall cycles.
- Trigger pulsed at cycles 50 and 200 of a run -> one result, drop_count=2, the run is not restarted.
- BRAM_ADDR_BITS=2, five back-to-back runs -> write addresses 0, 1, 2, 3, 0; clear afterwards -> out_ADDR=0 and drop_count=0.
- ap_rst_n low at LOAD cycle 100, then a new trigger -> no write from the aborted run, and the new run writes address 0 with accumulators starting from 0.
